// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM states, sizing constants and the leading-zero blanking helper.
package bin_to_bcd_seq_pkg;

  localparam int WIDTH   = 27;
  localparam int DIGITS  = 8;
  localparam int BCD_MAX = 99_999_999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A digit is lit when it or any more significant digit is nonzero; digit 0 always shows.
  function automatic logic [DIGITS-1:0] digit_mask_of(input logic [4*DIGITS-1:0] bcd_word);
    logic [DIGITS-1:0] mask;
    logic              seen;
    mask = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (bcd_word[4*i +: 4] != 4'd0);
      mask[i] = seen;
    end
    mask[0] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: one BCD digit, plus 3 when it is 5 or more.
module bcd_add3 (
  input  logic [3:0] value,
  output logic [3:0] adjusted
);

  assign adjusted = (value >= 4'd5) ? value + 4'd3 : value;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter feeding an 8-digit display: one bit per
// SHIFT cycle, out-of-range inputs short-circuit to an overflow result.
module bin_to_bcd_seq #(
  parameter int WIDTH  = bin_to_bcd_seq_pkg::WIDTH,
  parameter int DIGITS = bin_to_bcd_seq_pkg::DIGITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [4*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]   digit_mask
);

  import bin_to_bcd_seq_pkg::*;

  localparam int                CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_STEP  = CNT_W'(WIDTH - 1);
  localparam logic [DIGITS-1:0] MASK_RESET = DIGITS'(1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [WIDTH-1:0]    sr;
  logic [WIDTH-1:0]    sr_next;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] acc_adj;
  logic [4*DIGITS-1:0] acc_next;
  logic                bin_too_big;

  assign bin_too_big = 64'(bin) > 64'(BCD_MAX);

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .value    (acc[4*g +: 4]),
      .adjusted (acc_adj[4*g +: 4])
    );
  end

  assign {acc_next, sr_next} = {acc_adj, sr} << 1;

  // busy rises with the accepted start and stays up through the done-pulse cycle,
  // so a start coinciding with done is refused and a held start re-arms one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      bcd        <= '0;
      digit_mask <= MASK_RESET;
      cnt        <= '0;
      sr         <= '0;
      acc        <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !busy) begin
            busy <= 1'b1;
            sr   <= bin;
            acc  <= '0;
            cnt  <= '0;
            if (bin_too_big) begin
              state      <= DONE;
              overflow   <= 1'b1;
              digit_mask <= '1;
            end else begin
              state <= SHIFT;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state      <= DONE;
            bcd        <= acc_next;
            digit_mask <= digit_mask_of(acc_next);
            overflow   <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a timeline/arithmetic reference model
// compared every cycle, plus directed conversions with literal expectations.
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 27;
  localparam int DIGITS = 8;
  localparam int MAXVAL = 99_999_999;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [WIDTH-1:0]  bin = '0;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [31:0]       bcd;
  logic [7:0]        digit_mask;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // reference model state
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;
  logic        exp_ovf = 1'b0;
  logic [31:0] exp_bcd = '0;
  logic [7:0]  exp_mask = 8'h01;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .bcd        (bcd),
    .digit_mask (digit_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] to_bcd(input int unsigned v);
    logic [31:0]  r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] mask_of_value(input int unsigned v);
    int          nd;
    int unsigned t;
    nd = 1;
    t  = v / 10;
    while (t > 0) begin
      nd++;
      t = t / 10;
    end
    return 8'((1 << nd) - 1);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: latency 1 for overflow, WIDTH+1 otherwise; results land one edge before done,
  // busy spans accept edge to the end of the done cycle.
  initial begin
    int          n;
    int          k;
    int          lat;
    bit          pending;
    int unsigned val;
    n = 0; k = 0; lat = 0; pending = 1'b0; val = 0;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        pending  = 1'b0;
        exp_busy = 1'b0;
        exp_done = 1'b0;
        exp_ovf  = 1'b0;
        exp_bcd  = '0;
        exp_mask = 8'h01;
      end else begin
        n++;
        if (pending && n == k + lat + 1) begin
          pending  = 1'b0;
          exp_busy = 1'b0;
          exp_done = 1'b0;
        end else if (pending && n == k + lat) begin
          exp_done = 1'b1;
        end else if (!pending && start) begin
          pending  = 1'b1;
          k        = n;
          val      = int'(bin);
          lat      = (val > MAXVAL) ? 1 : WIDTH + 1;
          exp_busy = 1'b1;
        end
        if (pending && n == k + lat - 1) begin
          if (val > MAXVAL) begin
            exp_ovf  = 1'b1;
            exp_mask = 8'hFF;
          end else begin
            exp_ovf  = 1'b0;
            exp_bcd  = to_bcd(val);
            exp_mask = mask_of_value(val);
          end
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        checkVal("cyc_busy", 32'(busy), 32'(exp_busy));
        checkVal("cyc_done", 32'(done), 32'(exp_done));
        checkVal("cyc_overflow", 32'(overflow), 32'(exp_ovf));
        checkVal("cyc_bcd", bcd, exp_bcd);
        checkVal("cyc_mask", 32'(digit_mask), 32'(exp_mask));
      end
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] v);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] lit_bcd, input logic [7:0] lit_mask,
                             input logic lit_ovf, input int lit_lat);
    int edges;
    edges = 0;
    while (done !== 1'b1 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s_timeout: done not seen within %0d cycles", name, edges);
    end else begin
      checkVal({name, "_latency"}, 32'(edges), 32'(lit_lat));
      checkVal({name, "_bcd"}, bcd, lit_bcd);
      checkVal({name, "_mask"}, 32'(digit_mask), 32'(lit_mask));
      checkVal({name, "_overflow"}, 32'(overflow), 32'(lit_ovf));
      checkVal({name, "_model_bcd"}, exp_bcd, lit_bcd);
      checkVal({name, "_model_mask"}, 32'(exp_mask), 32'(lit_mask));
      @(negedge clk);
      checkVal({name, "_busy_after"}, 32'(busy), 32'd0);
      checkVal({name, "_done_after"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int dones;
    $display("[TB] starting bin_to_bcd_seq bench");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("reset_busy", 32'(busy), 32'd0);
    checkVal("reset_done", 32'(done), 32'd0);
    checkVal("reset_bcd", bcd, 32'h0);
    checkVal("reset_mask", 32'(digit_mask), 32'h01);
    reset  = 1'b1;
    cmp_en = 1'b1;

    applyStimulus(27'd0);
    checkOutput("zero", 32'h0000_0000, 8'h01, 1'b0, 28);

    applyStimulus(27'd42);
    bin = 27'd7;
    checkOutput("fortytwo", 32'h0000_0042, 8'h03, 1'b0, 28);

    applyStimulus(27'd100_000_000);
    checkOutput("overflow", 32'h0000_0042, 8'hFF, 1'b1, 1);

    applyStimulus(27'd24_000_042);
    checkOutput("full24", 32'h2400_0042, 8'hFF, 1'b0, 28);

    applyStimulus(27'd99_999_999);
    checkOutput("max", 32'h9999_9999, 8'hFF, 1'b0, 28);

    // start held high: re-triggers on each return to idle
    @(negedge clk);
    bin   = 27'd5;
    start = 1'b1;
    dones = 0;
    for (int e = 0; e < 65; e++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    checkVal("held_start_dones", 32'(dones), 32'd2);
    repeat (40) @(negedge clk);
    checkVal("held_start_bcd", bcd, 32'h0000_0005);

    // start pulse while busy is ignored
    applyStimulus(27'd31415);
    dones = 0;
    for (int e = 0; e < 60; e++) begin
      if (e == 9) begin
        bin   = 27'd5;
        start = 1'b1;
      end else if (e == 10) begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checkVal("busy_reject_dones", 32'(dones), 32'd1);
    checkVal("busy_reject_bcd", bcd, 32'h0003_1415);
    checkVal("busy_reject_mask", 32'(digit_mask), 32'h1F);

    // reset in the middle of SHIFT
    applyStimulus(27'd99_999_999);
    repeat (15) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkVal("midreset_busy", 32'(busy), 32'd0);
    checkVal("midreset_done", 32'(done), 32'd0);
    checkVal("midreset_overflow", 32'(overflow), 32'd0);
    checkVal("midreset_bcd", bcd, 32'h0);
    checkVal("midreset_mask", 32'(digit_mask), 32'h01);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (int e = 0; e < 35; e++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checkVal("midreset_no_done", 32'(dones), 32'd0);

    applyStimulus(27'd123);
    checkOutput("after_reset", 32'h0000_0123, 8'h07, 1'b0, 28);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 Parameter WIDTH, default 27: binary input width; 2^27 covers 99_999_999.
REQ-002 Parameter DIGITS, default 8: number of BCD digits, matching the 8-digit display.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  one clock; reset is asynchronous and active-low (reset=0 clears the block immediately).
REQ-005 start  input  1  conversion request; sampled only in IDLE.
REQ-006 bin  input  WIDTH  unsigned binary value; captured on the accepted start edge.
REQ-007 busy  output  1  high while a conversion is in progress (states SHIFT and DONE).
REQ-008 done  output  1  single-cycle pulse; bcd, digit_mask and overflow are valid and updated.
REQ-009 overflow  output  1  sticky result flag: last captured bin exceeded 99_999_999.
REQ-010 bcd  output  4*DIGITS  packed BCD, digit 7 at [31:28]; drives the display number input.
REQ-011 digit_mask  output  DIGITS  leading-zero-blanked anode enable; drives display AN_ON.

Function
REQ-012 FSM states IDLE, SHIFT, DONE; the encoding lives in the package.
- IDLE -> SHIFT on start=1 with bin <= 99_999_999.
- IDLE -> DONE on start=1 with bin > 99_999_999.
- SHIFT -> DONE after exactly WIDTH iterations.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 On an accepted start: bin is loaded into an internal shift register, a WIDTH-sized iteration counter and the BCD accumulator are cleared, and later changes to bin are ignored.
REQ-014 Each SHIFT cycle performs one double-dabble step:
- add 3 to every accumulator digit >= 5;
- then shift {accumulator, shift register} left by one bit.
REQ-015 Latency, with start accepted at edge k:
- normal path: done=1 during the cycle after edge k+WIDTH+1, which is 28 cycles for the default;
- overflow path: done=1 during the cycle after edge k+1.
REQ-016 bcd, digit_mask and overflow are registered and update only on the edge that enters DONE; they hold between conversions.
REQ-017 Normal completion: bcd is loaded from the accumulator and overflow is set to 0.
REQ-018 Overflow completion: bcd is left unchanged, overflow is set to 1 and digit_mask is set to all ones.
REQ-019 digit_mask[i] = 1 if digit i or any higher digit of the new bcd is nonzero; digit_mask[0] = 1 always.
REQ-020 A start while busy=1 is ignored, with no queuing; a start in the same cycle as DONE is also ignored.
REQ-021 A start held high continuously re-triggers a new conversion on each return to IDLE.
REQ-022 No digit of a normal-path result exceeds 9; the add-3 logic per digit is 4 bits wide with no carry between digits.

Reset
REQ-023 reset=0 asynchronously forces the following, regardless of the current state:
- state = IDLE;
- busy = 0 and done = 0;
- overflow = 0;
- bcd = 0;
- digit_mask = 8'h01;
- counter, shift register and accumulator = 0.
REQ-024 A reset during SHIFT aborts the conversion: no done pulse is produced and no output retains partial data.
REQ-025 Reset deassertion is used as-is; after release the first start is accepted no earlier than the first rising edge with reset=1.

Structure
REQ-026 A shared package holds:
- the state enum;
- constants BCD_MAX = 99_999_999, WIDTH and DIGITS;
- a function computing the digit_mask from a packed BCD word.
REQ-027 One sub-module, bcd_add3 (4-bit in/out, combinational, adds 3 if >= 5), is instantiated DIGITS times; everything else lives in bin_to_bcd_seq.

Verification
REQ-028 Conversion of 0: reset, then start with bin=0 -> done at cycle 28, bcd=32'h0000_0000, digit_mask=8'h01, overflow=0.
REQ-029 Conversion of 42: bin=42 -> bcd=32'h0000_0042, digit_mask=8'h03; bin changed to 7 during SHIFT -> result still 42.
REQ-030 Full-width conversions:
- bin=24_000_042 -> bcd=32'h2400_0042, digit_mask=8'hFF;
- bin=99_999_999 -> bcd=32'h9999_9999.
REQ-031 Overflow: after a 42 conversion, bin=100_000_000 -> done 2 cycles after start, overflow=1, bcd stays 32'h0000_0042, digit_mask=8'hFF.
REQ-032 Busy rejection: a start pulse at cycle 10 of a running conversion -> exactly one done pulse, and busy deasserts the cycle after done.
REQ-033 Reset mid-operation: reset=0 at cycle 15 of SHIFT -> outputs take their reset values immediately and no done pulse appears; a following start with bin=123 -> bcd=32'h0000_0123.
